nios_mult_cell_pipe: RTL

Parametrised, pipelined integer multiply cell for the Nios custom datapath. It supersedes the fixed 32-bit, low-half-only multiply cell. It adds selectable width, the high-half signed/unsigned multiply ops (MULXSS/MULXSU/MULXUU), an explicit valid/enable/flush pipeline control, and a sideband tag. It sits between the ALU operand mux and the writeback mux and is built from 16x16 partial products, so it maps onto dedicated multiplier blocks.

---
 rtl/nios_mult_cell_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nios_mult_cell_pipe.sv
// nios_mult_cell_pipe: 3-stage DATA_W x DATA_W integer multiply built from
// 17x17 signed partial products, returning the low or high product half.
module nios_mult_cell_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mul_in_valid,
    input  logic [1:0]        mul_op,
    input  logic [DATA_W-1:0] mul_src1,
    input  logic [DATA_W-1:0] mul_src2,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic              mul_en,
    input  logic              mul_flush,
    output logic              mul_out_valid,
    output logic [DATA_W-1:0] mul_result,
    output logic [TAG_W-1:0]  mul_out_tag,
    output logic              mul_busy
);
    localparam int L  = DATA_W / 16;
    localparam int NP = L * L;
    localparam int PW = 2 * DATA_W;

    logic               v1, v2, v3;
    logic [1:0]         op1, op2;
    logic [TAG_W-1:0]   tag1, tag2;
    logic [DATA_W:0]    a1, b1;
    logic               a_signed, b_signed;
    logic signed [16:0] a_limb [L];
    logic signed [16:0] b_limb [L];
    logic signed [33:0] pp_d [NP];
    logic signed [33:0] pp_q [NP];
    logic [PW-1:0]      prod;
    logic [DATA_W-1:0]  half;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (1'b1)
            (mul_op == 2'b01): begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            (mul_op == 2'b10): a_signed = 1'b1;
            default: ;
        endcase
    end

    // S1: operands extended to DATA_W+1 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a1   <= '0;
            b1   <= '0;
            op1  <= '0;
            tag1 <= '0;
        end else if (mul_en) begin
            a1   <= {a_signed & mul_src1[DATA_W-1], mul_src1};
            b1   <= {b_signed & mul_src2[DATA_W-1], mul_src2};
            op1  <= mul_op;
            tag1 <= mul_tag;
        end
    end

    // Only the top limb carries the extension bit, so only it can be negative
    always_comb begin
        for (int i = 0; i < L; i++) begin
            if (i == L - 1) begin
                a_limb[i] = a1[DATA_W -: 17];
                b_limb[i] = b1[DATA_W -: 17];
            end else begin
                a_limb[i] = {1'b0, a1[16*i +: 16]};
                b_limb[i] = {1'b0, b1[16*i +: 16]};
            end
        end
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < L; j++) begin
                pp_d[i*L+j] = 34'(a_limb[i]) * 34'(b_limb[j]);
            end
        end
    end

    // S2: multiplier output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NP; k++) pp_q[k] <= '0;
            op2  <= '0;
            tag2 <= '0;
        end else if (mul_en) begin
            for (int k = 0; k < NP; k++) pp_q[k] <= pp_d[k];
            op2  <= op1;
            tag2 <= tag1;
        end
    end

    always_comb begin
        prod = '0;
        for (int k = 0; k < NP; k++) begin
            prod = prod + (PW'(pp_q[k]) << (16 * ((k / L) + (k % L))));
        end
        half = (op2 == 2'b00) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
    end

    // S3 and valid chain; bubbles and flushed ops never touch the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            mul_result  <= '0;
            mul_out_tag <= '0;
        end else begin
            if (mul_flush) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
                v3 <= 1'b0;
            end else if (mul_en) begin
                v1 <= mul_in_valid;
                v2 <= v1;
                v3 <= v2;
            end
            if (mul_en && v2 && !mul_flush) begin
                mul_result  <= half;
                mul_out_tag <= tag2;
            end
        end
    end

    assign mul_out_valid = v3;
    assign mul_busy      = v1 | v2 | v3;

endmodule
